mem_arbiter: RTL and testbench

- Arbitrates the single RAM port between the pipeline's instruction-fetch requester and data-memory requester.
- Sequences each transaction against the RAM's ramstate handshake and returns per-requester wait signals. The hazard unit derives ihit/dhit from these wait signals.
- Data requests normally win. A streak counter guarantees forward progress for instruction fetch.
- A watchdog turns hung or errored RAM transactions into a flagged completion instead of a pipeline deadlock.

---
 rtl/mem_arbiter_if.sv | 40 ++++
 rtl/mem_arbiter.sv | 138 +++++++++++++
 tb/tb_mem_arbiter.sv | 308 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// Bus bundle joining the fetch requester, the data requester and the single
// RAM port to the memory arbiter. The arbiter takes the master view because
// it drives the RAM port and the per-requester wait/load returns; the
// environment (pipeline plus RAM) takes the slave view.
interface mem_arbiter_if;
  // Instruction-fetch requester
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;

  // Data-memory requester
  logic        dREN;
  logic        dWEN;
  logic [31:0] daddr;
  logic [31:0] dstore;
  logic        dwait;
  logic [31:0] dload;

  // RAM port
  logic        ramREN;
  logic        ramWEN;
  logic [31:0] ramaddr;
  logic [31:0] ramstore;
  logic [31:0] ramload;
  logic [1:0]  ramstate;

  // Sticky error flag
  logic        mem_err;

  modport master (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore, mem_err
  );

  modport slave (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore, mem_err
  );
endinterface

// File: rtl/mem_arbiter.sv
// Memory arbiter: shares one RAM port between instruction fetch and data
// access. Data normally wins; a streak counter forces a pending fetch through
// after MAX_DSTREAK data completions. A watchdog converts RAM errors and hung
// transactions into a completion carrying ERR_WORD and sets a sticky mem_err.
// One IDLE cycle separates every transaction, and all bus outputs are decoded
// combinationally from the registered state and the live inputs.
module mem_arbiter #(
  parameter int unsigned MAX_DSTREAK = 4,
  parameter int unsigned TIMEOUT     = 255,
  parameter logic [31:0] ERR_WORD    = 32'hBAD1BAD1
) (
  input logic           CLK,
  input logic           nRST,
  mem_arbiter_if.master bus
);

  localparam int unsigned SW = $clog2(MAX_DSTREAK + 1);
  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_DSTREAK);
  localparam logic [TW-1:0] TCOUNT_MAX = TW'(TIMEOUT);
  localparam logic [1:0] RAM_ACCESS = 2'd2;
  localparam logic [1:0] RAM_ERROR  = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISERV = 2'd1,
    DSERV = 2'd2
  } state_t;

  state_t        state;
  logic [SW-1:0] dstreak;
  logic [TW-1:0] tcount;
  logic          mem_err_q;

  logic d_req;
  logic live;
  logic access;
  logic abort;
  logic done;

  // Work out whether the granted requester is still asking and how this cycle ends for it.
  always_comb begin
    d_req  = bus.dREN | bus.dWEN;
    live   = 1'b0;
    if (state == ISERV) begin
      live = bus.iREN;
    end else if (state == DSERV) begin
      live = d_req;
    end
    access = (bus.ramstate == RAM_ACCESS);
    abort  = live & ~access & ((bus.ramstate == RAM_ERROR) | (tcount == TCOUNT_MAX));
    done   = (live & access) | abort;
  end

  // Drive the RAM port and the requester returns from the current grant.
  always_comb begin
    bus.ramREN   = 1'b0;
    bus.ramWEN   = 1'b0;
    bus.ramaddr  = 32'd0;
    bus.ramstore = 32'd0;
    bus.iwait    = 1'b1;
    bus.dwait    = 1'b1;
    bus.iload    = 32'd0;
    bus.dload    = 32'd0;
    bus.mem_err  = mem_err_q;
    case (state)
      ISERV: begin
        bus.ramaddr = bus.iaddr;
        bus.ramREN  = bus.iREN;
        if (done) begin
          bus.iwait = 1'b0;
          bus.iload = abort ? ERR_WORD : bus.ramload;
        end
      end
      DSERV: begin
        bus.ramaddr  = bus.daddr;
        bus.ramstore = bus.dstore;
        bus.ramWEN   = bus.dWEN;
        bus.ramREN   = bus.dREN & ~bus.dWEN;
        if (done) begin
          bus.dwait = 1'b0;
          bus.dload = abort ? ERR_WORD : bus.ramload;
        end
      end
      default: begin
      end
    endcase
  end

  // Grant sequencing, starvation streak, watchdog count and sticky error flag.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state     <= IDLE;
      dstreak   <= '0;
      tcount    <= '0;
      mem_err_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          tcount <= '0;
          if (d_req && bus.iREN && (dstreak == STREAK_MAX)) begin
            state <= ISERV;
          end else if (d_req) begin
            state <= DSERV;
          end else if (bus.iREN) begin
            state <= ISERV;
          end
        end
        ISERV: begin
          if (!live) begin
            state <= IDLE;
          end else if (done) begin
            state   <= IDLE;
            dstreak <= '0;
            if (abort) mem_err_q <= 1'b1;
          end else begin
            tcount <= tcount + TW'(1);
          end
        end
        DSERV: begin
          if (!live) begin
            state <= IDLE;
          end else if (done) begin
            state <= IDLE;
            if (bus.iREN && (dstreak != STREAK_MAX)) dstreak <= dstreak + SW'(1);
            if (abort) mem_err_q <= 1'b1;
          end else begin
            tcount <= tcount + TW'(1);
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter. A transaction-level model tracks who
// owns the RAM port, how long the current transaction has been in service and
// how many data completions have passed a waiting fetch; every cycle the
// DUT outputs are compared against what that model predicts. Directed
// scenarios come first, then a randomized phase.
module tb_mem_arbiter;

  localparam int unsigned MAX_DSTREAK = 4;
  localparam int unsigned TIMEOUT     = 255;
  localparam logic [31:0] ERR_WORD    = 32'hBAD1BAD1;

  localparam int OWN_NONE = 0;
  localparam int OWN_I    = 1;
  localparam int OWN_D    = 2;

  logic CLK;
  logic nRST;

  mem_arbiter_if bus ();

  mem_arbiter #(
    .MAX_DSTREAK (MAX_DSTREAK),
    .TIMEOUT     (TIMEOUT),
    .ERR_WORD    (ERR_WORD)
  ) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bus.master)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int m_owner  = OWN_NONE;
  int m_age    = 0;
  int m_streak = 0;
  bit m_err    = 1'b0;

  // Observations of the DUT's completion behaviour
  int cycle_no   = 0;
  int i_done_cnt = 0;
  int d_done_cnt = 0;
  int i_done_at  = -1;
  int d_done_at  = -1;
  int d_at_i     = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic apply_stimulus(input logic ire, input logic [31:0] ia,
                                input logic dre, input logic dwe,
                                input logic [31:0] da, input logic [31:0] ds,
                                input logic [1:0] rs, input logic [31:0] rl);
    bus.iREN     = ire;
    bus.iaddr    = ia;
    bus.dREN     = dre;
    bus.dWEN     = dwe;
    bus.daddr    = da;
    bus.dstore   = ds;
    bus.ramstate = rs;
    bus.ramload  = rl;
  endtask

  // Compare one cycle at the falling edge, then advance the model at the rising edge.
  task automatic check_output();
    logic        d_req;
    logic        grant_live;
    logic        e_iw, e_dw, e_rren, e_rwen;
    logic [31:0] e_ra, e_rs, e_iload, e_dload;
    bit          done, abort;
    @(negedge CLK);
    d_req   = bus.dREN | bus.dWEN;
    e_iw    = 1'b1;
    e_dw    = 1'b1;
    e_rren  = 1'b0;
    e_rwen  = 1'b0;
    e_ra    = 32'd0;
    e_rs    = 32'd0;
    e_iload = 32'd0;
    e_dload = 32'd0;
    done    = 1'b0;
    abort   = 1'b0;
    grant_live = (m_owner == OWN_I) ? bus.iREN : d_req;
    if (m_owner != OWN_NONE && grant_live) begin
      if (bus.ramstate == 2'd2) begin
        done = 1'b1;
      end else if (bus.ramstate == 2'd3 || m_age == int'(TIMEOUT) + 1) begin
        done  = 1'b1;
        abort = 1'b1;
      end
    end
    if (m_owner == OWN_I) begin
      e_ra   = bus.iaddr;
      e_rren = bus.iREN;
      if (done) begin
        e_iw    = 1'b0;
        e_iload = abort ? ERR_WORD : bus.ramload;
      end
    end else if (m_owner == OWN_D) begin
      e_ra   = bus.daddr;
      e_rs   = bus.dstore;
      e_rwen = bus.dWEN;
      e_rren = bus.dREN & ~bus.dWEN;
      if (done) begin
        e_dw    = 1'b0;
        e_dload = abort ? ERR_WORD : bus.ramload;
      end
    end
    check_val("iwait", bus.iwait, e_iw);
    check_val("dwait", bus.dwait, e_dw);
    check_val("ramREN", bus.ramREN, e_rren);
    check_val("ramWEN", bus.ramWEN, e_rwen);
    check_val("ramaddr", bus.ramaddr, e_ra);
    check_val("ramstore", bus.ramstore, e_rs);
    check_val("mem_err", bus.mem_err, m_err);
    if (!e_iw) check_val("iload", bus.iload, e_iload);
    if (!e_dw) check_val("dload", bus.dload, e_dload);
    if (bus.iwait === 1'b0) begin
      i_done_cnt++;
      i_done_at = cycle_no;
      d_at_i    = d_done_cnt;
    end
    if (bus.dwait === 1'b0) begin
      d_done_cnt++;
      d_done_at = cycle_no;
    end
    @(posedge CLK);
    case (m_owner)
      OWN_NONE: begin
        if (d_req && bus.iREN && m_streak == int'(MAX_DSTREAK)) m_owner = OWN_I;
        else if (d_req) m_owner = OWN_D;
        else if (bus.iREN) m_owner = OWN_I;
        m_age = 1;
      end
      OWN_I: begin
        if (!grant_live) begin
          m_owner = OWN_NONE;
        end else if (done) begin
          m_owner  = OWN_NONE;
          m_streak = 0;
          if (abort) m_err = 1'b1;
        end else begin
          m_age++;
        end
      end
      default: begin
        if (!grant_live) begin
          m_owner = OWN_NONE;
        end else if (done) begin
          m_owner = OWN_NONE;
          if (bus.iREN && m_streak < int'(MAX_DSTREAK)) m_streak++;
          if (abort) m_err = 1'b1;
        end else begin
          m_age++;
        end
      end
    endcase
    cycle_no++;
    #1;
  endtask

  task automatic check_reset_values(input string phase);
    check_val({phase, " ramREN"}, bus.ramREN, 1'b0);
    check_val({phase, " ramWEN"}, bus.ramWEN, 1'b0);
    check_val({phase, " ramaddr"}, bus.ramaddr, 32'd0);
    check_val({phase, " ramstore"}, bus.ramstore, 32'd0);
    check_val({phase, " iwait"}, bus.iwait, 1'b1);
    check_val({phase, " dwait"}, bus.dwait, 1'b1);
    check_val({phase, " iload"}, bus.iload, 32'd0);
    check_val({phase, " dload"}, bus.dload, 32'd0);
    check_val({phase, " mem_err"}, bus.mem_err, 1'b0);
  endtask

  // Pulse reset between clock edges, checking the immediate and held values.
  task automatic do_reset();
    nRST = 1'b0;
    #2;
    check_reset_values("rst_now");
    @(posedge CLK);
    #1;
    check_reset_values("rst_hold");
    nRST     = 1'b1;
    m_owner  = OWN_NONE;
    m_age    = 0;
    m_streak = 0;
    m_err    = 1'b0;
  endtask

  int s;
  int i0;
  int d0;
  logic [1:0] rs;
  int r;

  initial begin
    nRST = 1'b1;
    apply_stimulus(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 2'd0, 32'd0);
    #1;
    do_reset();

    // Fetch only: two BUSY cycles then ACCESS
    s = cycle_no; i0 = i_done_cnt;
    apply_stimulus(1'b1, 32'h40, 1'b0, 1'b0, 32'd0, 32'd0, 2'd1, 32'd0);
    check_output();
    check_output();
    check_output();
    apply_stimulus(1'b1, 32'h40, 1'b0, 1'b0, 32'd0, 32'd0, 2'd2, 32'h8C010004);
    check_output();
    apply_stimulus(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 2'd0, 32'd0);
    check_output();
    check_val("fetch_count", i_done_cnt - i0, 1);
    check_val("fetch_cycle", i_done_at - s, 3);

    // Simultaneous requests: data write first, fetch after one IDLE cycle
    s = cycle_no;
    apply_stimulus(1'b1, 32'h44, 1'b0, 1'b1, 32'h100, 32'hDEAD, 2'd2, 32'h11112222);
    check_output();
    check_output();
    apply_stimulus(1'b1, 32'h44, 1'b0, 1'b0, 32'h100, 32'hDEAD, 2'd2, 32'h33334444);
    check_output();
    check_output();
    apply_stimulus(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 2'd0, 32'd0);
    check_output();
    check_val("simul_data_cycle", d_done_at - s, 1);
    check_val("simul_fetch_cycle", i_done_at - s, 3);

    // Starvation guard: four data completions then the fetch is forced through
    s = cycle_no; i0 = i_done_cnt; d0 = d_done_cnt;
    for (int k = 0; k < 14; k++) begin
      apply_stimulus(1'b1, 32'h48, 1'b1, 1'b0, 32'h200 + 32'(k), 32'd0, 2'd2, $urandom);
      check_output();
    end
    check_val("starve_fetch_count", i_done_cnt - i0, 1);
    check_val("starve_data_before", d_at_i - d0, 4);
    check_val("starve_fetch_cycle", i_done_at - s, 9);
    apply_stimulus(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 2'd0, 32'd0);
    check_output();

    // Timeout: RAM stuck BUSY
    s = cycle_no; d0 = d_done_cnt;
    for (int k = 0; k < 257; k++) begin
      apply_stimulus(1'b0, 32'd0, 1'b1, 1'b0, 32'h300, 32'd0, 2'd1, 32'h55555555);
      check_output();
    end
    apply_stimulus(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 2'd0, 32'd0);
    check_output();
    check_output();
    check_val("timeout_count", d_done_cnt - d0, 1);
    check_val("timeout_cycle", d_done_at - s, 256);
    check_val("timeout_sticky", bus.mem_err, 1'b1);

    // ERROR during ISERV
    s = cycle_no;
    apply_stimulus(1'b1, 32'h60, 1'b0, 1'b0, 32'd0, 32'd0, 2'd3, 32'h77777777);
    check_output();
    check_output();
    apply_stimulus(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 2'd0, 32'd0);
    check_output();
    check_val("error_cycle", i_done_at - s, 1);

    // Withdrawal in DSERV
    d0 = d_done_cnt;
    apply_stimulus(1'b0, 32'd0, 1'b1, 1'b0, 32'h400, 32'd0, 2'd1, 32'd0);
    check_output();
    check_output();
    apply_stimulus(1'b0, 32'd0, 1'b0, 1'b0, 32'h400, 32'd0, 2'd2, 32'd0);
    check_output();
    check_output();
    check_val("withdraw_no_done", d_done_cnt - d0, 0);

    // Reset mid-ISERV
    apply_stimulus(1'b1, 32'h80, 1'b0, 1'b0, 32'd0, 32'd0, 2'd1, 32'd0);
    check_output();
    check_output();
    do_reset();
    check_output();
    apply_stimulus(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 2'd0, 32'd0);
    check_output();
    check_output();

    // Randomized traffic
    for (int k = 0; k < 3000; k++) begin
      r = $urandom_range(0, 99);
      if (r < 40) rs = 2'd1;
      else if (r < 85) rs = 2'd2;
      else if (r < 92) rs = 2'd0;
      else rs = 2'd3;
      apply_stimulus($urandom_range(0, 9) < 7, $urandom,
                     $urandom_range(0, 9) < 5, $urandom_range(0, 9) < 3,
                     $urandom, $urandom, rs, $urandom);
      check_output();
      if ($urandom_range(0, 499) == 0) do_reset();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
